min_receive_fsm: RTL

//  Receive-side MIN frame decoder. Consumes bytes from the UART receiver on the RS232_RX path,

---
 rtl/min_receive_fsm.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/min_receive_fsm.sv
// rtl/min_receive_fsm.sv - MIN receive-side frame decoder: header hunt, unstuffing, CRC-32 and EOF check.
module min_receive_fsm #(
  parameter int N_DATA_BYTE = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic [7:0]               i_data,
  output logic                     o_valid,
  output logic [7:0]               o_id,
  output logic [7:0]               o_len,
  output logic [8*N_DATA_BYTE-1:0] o_data,
  output logic                     o_crc_err,
  output logic                     o_frame_err,
  output logic                     o_busy
);

  localparam logic [7:0] LP_N = 8'(N_DATA_BYTE);

  typedef enum logic [2:0] {S_HUNT, S_ID, S_LEN, S_PAYLOAD, S_CRC, S_EOF} state_t;

  function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  state_t                   r_state,     w_state_nxt;
  logic [1:0]               r_aa_cnt,    w_aa_cnt_nxt;
  logic [31:0]              r_crc,       w_crc_nxt;
  logic [31:0]              r_crc_rx,    w_crc_rx_nxt;
  logic [7:0]               r_id,        w_id_nxt;
  logic [7:0]               r_len,       w_len_nxt;
  logic [7:0]               r_cnt,       w_cnt_nxt;
  logic [8*N_DATA_BYTE-1:0] r_buf,       w_buf_nxt;
  logic                     r_valid,     w_valid_nxt;
  logic                     r_crc_err,   w_crc_err_nxt;
  logic                     r_frame_err, w_frame_err_nxt;
  logic [7:0]               r_o_id,      w_o_id_nxt;
  logic [7:0]               r_o_len,     w_o_len_nxt;
  logic [8*N_DATA_BYTE-1:0] r_o_data,    w_o_data_nxt;

  logic        w_acc, w_is_aa, w_header, w_stuff;
  logic [31:0] w_crc_upd;

  assign w_acc     = i_en && i_valid;
  assign w_is_aa   = (i_data == 8'hAA);
  assign w_header  = w_acc && w_is_aa && (r_aa_cnt == 2'd2);
  // EOF is excluded: its 0x55 is the terminator, never a stuff byte.
  assign w_stuff   = w_acc && (r_state != S_HUNT) && (r_state != S_EOF) &&
                     (i_data == 8'h55) && (r_aa_cnt == 2'd2);
  assign w_crc_upd = f_crc_byte(r_crc, i_data);

  always_comb begin
    w_state_nxt     = r_state;
    w_aa_cnt_nxt    = r_aa_cnt;
    w_crc_nxt       = r_crc;
    w_crc_rx_nxt    = r_crc_rx;
    w_id_nxt        = r_id;
    w_len_nxt       = r_len;
    w_cnt_nxt       = r_cnt;
    w_buf_nxt       = r_buf;
    w_valid_nxt     = 1'b0;
    w_crc_err_nxt   = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_o_id_nxt      = r_o_id;
    w_o_len_nxt     = r_o_len;
    w_o_data_nxt    = r_o_data;
    if (w_acc) begin
      if (w_header)     w_aa_cnt_nxt = 2'd0;
      else if (w_is_aa) w_aa_cnt_nxt = (r_aa_cnt == 2'd2) ? 2'd2 : r_aa_cnt + 2'd1;
      else              w_aa_cnt_nxt = 2'd0;

      if (w_header) begin
        w_state_nxt = S_ID;
        w_crc_nxt   = 32'hFFFFFFFF;
        w_buf_nxt   = '0;
        w_cnt_nxt   = 8'd0;
      end else if (!w_stuff) begin
        unique case (r_state)
          S_HUNT: ;
          S_ID: begin
            w_id_nxt    = i_data;
            w_crc_nxt   = w_crc_upd;
            w_state_nxt = S_LEN;
          end
          S_LEN: begin
            w_len_nxt = i_data;
            w_crc_nxt = w_crc_upd;
            w_cnt_nxt = 8'd0;
            if (i_data > LP_N) begin
              w_frame_err_nxt = 1'b1;
              w_state_nxt     = S_HUNT;
            end else if (i_data == 8'd0) begin
              w_state_nxt = S_CRC;
            end else begin
              w_state_nxt = S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            for (int i = 0; i < N_DATA_BYTE; i++)
              if (r_cnt == 8'(i)) w_buf_nxt[8*(N_DATA_BYTE-1-i) +: 8] = i_data;
            w_crc_nxt = w_crc_upd;
            if (r_cnt == r_len - 8'd1) begin
              w_cnt_nxt   = 8'd0;
              w_state_nxt = S_CRC;
            end else begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end
          S_CRC: begin
            w_crc_rx_nxt = {r_crc_rx[23:0], i_data};
            if (r_cnt == 8'd3) begin
              w_cnt_nxt   = 8'd0;
              w_state_nxt = S_EOF;
            end else begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end
          S_EOF: begin
            w_state_nxt = S_HUNT;
            if (i_data != 8'h55) begin
              w_frame_err_nxt = 1'b1;
            end else if (r_crc_rx != ~r_crc) begin
              w_crc_err_nxt = 1'b1;
            end else begin
              w_valid_nxt  = 1'b1;
              w_o_id_nxt   = r_id;
              w_o_len_nxt  = r_len;
              w_o_data_nxt = r_buf;
            end
          end
          default: w_state_nxt = S_HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_HUNT;
      r_aa_cnt    <= 2'd0;
      r_crc       <= 32'hFFFFFFFF;
      r_crc_rx    <= 32'd0;
      r_id        <= 8'd0;
      r_len       <= 8'd0;
      r_cnt       <= 8'd0;
      r_buf       <= '0;
      r_valid     <= 1'b0;
      r_crc_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_o_id      <= 8'd0;
      r_o_len     <= 8'd0;
      r_o_data    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_aa_cnt    <= w_aa_cnt_nxt;
      r_crc       <= w_crc_nxt;
      r_crc_rx    <= w_crc_rx_nxt;
      r_id        <= w_id_nxt;
      r_len       <= w_len_nxt;
      r_cnt       <= w_cnt_nxt;
      r_buf       <= w_buf_nxt;
      r_valid     <= w_valid_nxt;
      r_crc_err   <= w_crc_err_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_o_id      <= w_o_id_nxt;
      r_o_len     <= w_o_len_nxt;
      r_o_data    <= w_o_data_nxt;
    end
  end

  assign o_valid     = r_valid;
  assign o_crc_err   = r_crc_err;
  assign o_frame_err = r_frame_err;
  assign o_id        = r_o_id;
  assign o_len       = r_o_len;
  assign o_data      = r_o_data;
  assign o_busy      = (r_state != S_HUNT);

endmodule
